// File: rtl/dsa_pkg.sv
// dsa_pkg
// Shared types and constants for the bilinear DSA job scheduler.
//   sched_state_t : scheduler FSM states
//   CFG_W         : width of each job configuration field
//   PERF_W        : width of the job cycle counter
//   job_cfg_t     : latched job configuration {in_w, in_h, scale_q88}
package dsa_pkg;

  localparam int CFG_W  = 16;
  localparam int PERF_W = 32;

  typedef enum logic [2:0] {
    INIT_CLR,
    IDLE,
    CLEAR,
    LAUNCH,
    RUN
  } sched_state_t;

  typedef struct packed {
    logic [CFG_W-1:0] in_w;
    logic [CFG_W-1:0] in_h;
    logic [CFG_W-1:0] scale_q88;
  } job_cfg_t;

endpackage

// File: rtl/dsa_clr_seq.sv
// dsa_clr_seq
// Address sweeper used to zero the output BRAM. After reset, or after a
// one-cycle start, it walks addresses 0 .. 2^AW-1, one per cycle, then
// goes inactive with the address wrapped back to 0.
// Ports:
//   clk_50  in   system clock
//   rst     in   synchronous active-high reset (begins a sweep)
//   start   in   begin a new sweep from address 0
//   active  out  sweep in progress (doubles as the write enable)
//   addr    out  current write address
//   last    out  this cycle writes the final address
module dsa_clr_seq
  import dsa_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk_50,
  input  logic          rst,
  input  logic          start,
  output logic          active,
  output logic [AW-1:0] addr,
  output logic          last
);

  assign last = active && (addr == {AW{1'b1}});

  // Reset starts a sweep immediately so the BRAM is cleared at power-up
  // without needing an explicit start from the scheduler.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      active <= 1'b1;
      addr   <= '0;
    end else if (start) begin
      active <= 1'b1;
      addr   <= '0;
    end else if (active) begin
      addr <= addr + 1'b1;
      if (last) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dsa_job_sched.sv
// dsa_job_sched
// Job scheduler for the bilinear DSA. Accepts single-cycle start requests
// from the switch or JTAG, latches job configuration and engine select,
// clears the output BRAM, launches exactly one core and supervises its
// completion with a timeout.
// Ports:
//   clk_50, rst                     clock, synchronous active-high reset
//   req_sw, req_jtag, req_simd      start requests and engine mode
//   cfg_in_w/cfg_in_h/cfg_scale_q88 job parameters at request time
//   busy_*/done_*                   core status (only selected done used)
//   start_seq, start_simd           one-cycle launch pulses
//   sel_simd, job_*                 latched engine select and parameters
//   clr_active, clr_waddr, clr_we   BRAM clear write port
//   sched_busy                      high outside IDLE
//   job_done, job_tmo, req_drop     sticky status, cleared on accept
//   job_cycles, job_count           perf counters
module dsa_job_sched
  import dsa_pkg::*;
#(
  parameter int AW    = 12,
  parameter int TMO_W = 24
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic              req_sw,
  input  logic              req_jtag,
  input  logic              req_simd,
  input  logic [CFG_W-1:0]  cfg_in_w,
  input  logic [CFG_W-1:0]  cfg_in_h,
  input  logic [CFG_W-1:0]  cfg_scale_q88,
  input  logic              busy_seq,
  input  logic              done_seq,
  input  logic              busy_simd,
  input  logic              done_simd,
  output logic              start_seq,
  output logic              start_simd,
  output logic              sel_simd,
  output logic [CFG_W-1:0]  job_in_w,
  output logic [CFG_W-1:0]  job_in_h,
  output logic [CFG_W-1:0]  job_scale_q88,
  output logic              clr_active,
  output logic [AW-1:0]     clr_waddr,
  output logic              clr_we,
  output logic              sched_busy,
  output logic              job_done,
  output logic              job_tmo,
  output logic              req_drop,
  output logic [PERF_W-1:0] job_cycles,
  output logic [15:0]       job_count
);

  sched_state_t     state;
  job_cfg_t         job_cfg;
  logic [TMO_W-1:0] tmo_cnt;
  logic             any_req;
  logic             sel_done;
  logic             tmo_hit;
  logic             clr_start;
  logic             clr_run;
  logic             clr_last;

  // Core busy lines are not needed: completion is judged by done alone.
  logic unused_busy;
  assign unused_busy = busy_seq ^ busy_simd;

  assign any_req   = req_sw | req_jtag;
  assign sel_done  = sel_simd ? done_simd : done_seq;
  assign tmo_hit   = (tmo_cnt == {TMO_W{1'b1}});
  assign clr_start = (state == IDLE) && any_req;

  assign job_in_w      = job_cfg.in_w;
  assign job_in_h      = job_cfg.in_h;
  assign job_scale_q88 = job_cfg.scale_q88;

  // The same sweeper serves the power-up clear and the per-job clear; its
  // registered active flag is both the port ownership flag and write enable.
  dsa_clr_seq #(
    .AW (AW)
  ) u_clr_seq (
    .clk_50 (clk_50),
    .rst    (rst),
    .start  (clr_start),
    .active (clr_run),
    .addr   (clr_waddr),
    .last   (clr_last)
  );

  assign clr_active = clr_run;
  assign clr_we     = clr_run;

  // Scheduler FSM with registered status, perf counters and timeout.
  // The timeout counter starts at 1 on the first RUN cycle, so reaching
  // all-ones means 2^TMO_W-1 RUN cycles have elapsed. Done is tested first
  // so a completion coinciding with the timeout still counts as normal.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state      <= INIT_CLR;
      sched_busy <= 1'b1;
      sel_simd   <= 1'b0;
      job_cfg    <= '0;
      job_done   <= 1'b0;
      job_tmo    <= 1'b0;
      req_drop   <= 1'b0;
      job_cycles <= '0;
      job_count  <= '0;
      start_seq  <= 1'b0;
      start_simd <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      start_seq  <= 1'b0;
      start_simd <= 1'b0;

      if (any_req && (state != IDLE)) begin
        req_drop <= 1'b1;
      end

      case (state)
        INIT_CLR: begin
          if (clr_last) begin
            state      <= IDLE;
            sched_busy <= 1'b0;
          end
        end

        IDLE: begin
          if (any_req) begin
            state      <= CLEAR;
            sched_busy <= 1'b1;
            sel_simd   <= req_simd;
            job_cfg    <= '{in_w: cfg_in_w, in_h: cfg_in_h, scale_q88: cfg_scale_q88};
            job_done   <= 1'b0;
            job_tmo    <= 1'b0;
            req_drop   <= 1'b0;
            job_cycles <= '0;
          end
        end

        CLEAR: begin
          if (clr_last) begin
            state      <= LAUNCH;
            start_simd <= sel_simd;
            start_seq  <= ~sel_simd;
          end
        end

        LAUNCH: begin
          state      <= RUN;
          job_cycles <= PERF_W'(1);
          tmo_cnt    <= TMO_W'(1);
        end

        RUN: begin
          if (job_cycles != {PERF_W{1'b1}}) begin
            job_cycles <= job_cycles + 1'b1;
          end
          tmo_cnt <= tmo_cnt + 1'b1;
          if (sel_done) begin
            job_done   <= 1'b1;
            job_count  <= job_count + 1'b1;
            state      <= IDLE;
            sched_busy <= 1'b0;
          end else if (tmo_hit) begin
            job_tmo    <= 1'b1;
            state      <= IDLE;
            sched_busy <= 1'b0;
          end
        end

        default: begin
          state      <= INIT_CLR;
          sched_busy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/dsa_job_sched.md
# dsa_job_sched

Job scheduler for the bilinear DSA. Accepts start requests from the debounced switch and from the JTAG config path, then latches the job configuration and engine selection. It clears the output BRAM through its own write port, launches exactly one core (`bilinear_seq` or `bilinear_simd4`), and supervises completion with a timeout. It sits between the request sources and the two cores, and drives the core-select and mem_out write-source muxes in the DSA top.

## Interface
- `AW`, 12: BRAM address width; clear sweeps 2^AW words.
- `TMO_W`, 24: timeout counter width; timeout fires after 2^TMO_W−1 RUN cycles.
- `clk_50`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_sw`  in  1  single-cycle start request from the switch debouncer.
- `req_jtag`  in  1  single-cycle start request from JTAG.
- `req_simd`  in  1  engine mode at request time (1 = SIMD4).
- `cfg_in_w`, `cfg_in_h`, `cfg_scale_q88`  in  16 each  job parameters at request time.
- `busy_seq`, `done_seq`  in  1 each  sequential core status.
- `busy_simd`, `done_simd`  in  1 each  SIMD4 core status.
- `start_seq`, `start_simd`  out  1 each  one-cycle launch pulses.
- `sel_simd`  out  1  latched engine select; drives the top-level core muxes.
- `job_in_w`, `job_in_h`, `job_scale_q88`  out  16 each  latched job parameters.
- `clr_active`  out  1  scheduler owns the mem_out write port.
- `clr_waddr`  out  AW  clear address; write data is implicitly 0.
- `clr_we`  out  1  clear write enable.
- `sched_busy`  out  1  high in every state except IDLE.
- `job_done`  out  1  sticky; set on normal completion, cleared on next accept.
- `job_tmo`  out  1  sticky; set on timeout, cleared on next accept.
- `req_drop`  out  1  sticky; a request arrived while not IDLE; cleared on next accept.
- `job_cycles`  out  32  cycles from LAUNCH up to and including the done cycle.
- `job_count`  out  16  completed jobs (normal only), wraps at 65535→0.

## Operation
- States: INIT_CLR, IDLE, CLEAR, LAUNCH, RUN.
- Reset:
  - State goes to INIT_CLR and `clr_waddr` to 0.
  - `sel_simd`, `job_*` parameters, `job_done`, `job_tmo`, `req_drop`, `job_cycles`, `job_count` all go to 0.
  - `start_*` go to 0.
- INIT_CLR and CLEAR:
  - `clr_active` = `clr_we` = 1; `clr_waddr` increments each cycle from 0.
  - On the cycle with `clr_waddr` = 2^AW−1: INIT_CLR → IDLE, CLEAR → LAUNCH.
  - `clr_waddr` wraps to 0.
- Accepting a request in IDLE:
  - Accept when `req_sw | req_jtag`.
  - Latch `req_simd` into `sel_simd` and the `cfg_*` inputs into the `job_*` outputs.
  - Clear `job_done`, `job_tmo`, `req_drop`, `job_cycles`; go to CLEAR.
  - Simultaneous `req_sw` and `req_jtag` count as one accept; neither sets `req_drop`.
- LAUNCH:
  - One cycle. `start_simd` = `sel_simd`, `start_seq` = ~`sel_simd`; set `job_cycles` = 1; go to RUN.
- RUN:
  - `job_cycles` saturating-increments at 2^32−1.
  - Only the selected core's `done_*` is observed; the other core's done and both busy inputs are ignored.
  - Selected done: set `job_done`, increment `job_count`, go to IDLE.
  - Timeout counter reaching all-ones before done: set `job_tmo`, go to IDLE.
  - If done and timeout coincide, done wins.
- Any request outside IDLE is ignored and sets `req_drop`. This includes INIT_CLR.
- `sel_simd` and the `job_*` parameters hold until the next accept, so muxes and perf readout stay stable after completion.
- `rst` mid-job: abort immediately and restart INIT_CLR. No start pulse is emitted during reset.

## Timing
- All outputs are registered.
- Accept at cycle T:
  - `sched_busy`, `clr_we` high from T+1 through T+2^AW.
  - Start pulse at T+2^AW+1.
  - RUN from T+2^AW+2.
- Selected done sampled at cycle D in RUN: `job_done` = 1 and `sched_busy` = 0 at D+1.
- Earliest re-accept is cycle D+1 (IDLE).
- Reset deasserted at cycle R: INIT_CLR writes cycles R+1 … R+2^AW; IDLE from R+2^AW+1.

## Structure
- Package `dsa_pkg` holds:
  - the state enum `sched_state_t`;
  - `CFG_W = 16` and `PERF_W = 32`;
  - a `job_cfg_t` struct {in_w, in_h, scale_q88}.
- One natural sub-module: `dsa_clr_seq`, an address sweeper with start/active/last outputs, shared by INIT_CLR and CLEAR.
- FSM, timeout and counters stay inline.

## Test plan
Bench uses AW=4 and TMO_W=6.
- Reset release → 16 writes to addresses 0..15 with `clr_we` = 1; IDLE at R+17; all status outputs 0.
- `req_sw` with `req_simd`=0, cfg 64/64/205 → `start_seq` pulse at T+17 and `job_*` = 64/64/205. `done_seq` 10 cycles later → `job_done` = 1, `job_cycles` = 11, `job_count` = 1.
- `req_jtag` with `req_simd`=1 → only `start_simd` pulses. A `done_seq` in RUN is ignored; a later `done_simd` completes the job.
- Hold done low → `job_tmo` = 1 after 63 RUN cycles; `job_count` unchanged; next request clears `job_tmo`.
- `req_sw` during CLEAR → `req_drop` = 1 with no second job. `req_sw` and `req_jtag` together in IDLE → one job and `req_drop` = 0.
- `rst` asserted mid-RUN → next cycle in INIT_CLR; no start pulses; `job_count` = 0.
